// File: rtl/mapper_mem_arbiter.sv
// Two-requester memory arbiter: mapper CPU port and loader port share one memory port.
// CPU has priority; a saturating counter forces a loader grant after STARVE_MAX CPU wins.
//
// state    | meaning
// IDLE     | waiting for a request, grant decided here
// CPU_BUSY | CPU transaction outstanding on the memory port
// LD_BUSY  | loader write outstanding on the memory port
// DONE     | one-cycle gap after completion, requests ignored
module mapper_mem_arbiter #(
   parameter int          ADDR_W     = 27,
   parameter logic [3:0]  STARVE_MAX = 4'd15
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_rnw,
   input  logic              cpu_sram,
   input  logic [7:0]        cpu_wdata,
   output logic              cpu_ack,
   output logic [7:0]        cpu_rdata,
   input  logic              ld_req,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [7:0]        ld_wdata,
   output logic              ld_ack,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic              mem_sram,
   output logic [7:0]        mem_wdata,
   input  logic              mem_ack,
   input  logic [7:0]        mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, CPU_BUSY, LD_BUSY, DONE} state_t;

   state_t            state_q, state_d;
   logic [3:0]        starve_q, starve_d;
   logic              mem_req_q, mem_req_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_we_q, mem_we_d;
   logic              mem_sram_q, mem_sram_d;
   logic [7:0]        mem_wdata_q, mem_wdata_d;
   logic              cpu_ack_q, cpu_ack_d;
   logic              ld_ack_q, ld_ack_d;
   logic [7:0]        cpu_rdata_q, cpu_rdata_d;
   logic              grant_cpu;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         starve_q    <= 4'd0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_sram_q  <= 1'b0;
         mem_wdata_q <= 8'h00;
         cpu_ack_q   <= 1'b0;
         ld_ack_q    <= 1'b0;
         cpu_rdata_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         mem_sram_q  <= mem_sram_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_ack_q   <= cpu_ack_d;
         ld_ack_q    <= ld_ack_d;
         cpu_rdata_q <= cpu_rdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;
      mem_we_d    = mem_we_q;
      mem_sram_d  = mem_sram_q;
      mem_wdata_d = mem_wdata_q;
      cpu_ack_d   = 1'b0;
      ld_ack_d    = 1'b0;
      cpu_rdata_d = cpu_rdata_q;
      grant_cpu   = cpu_req && !(ld_req && (starve_q == STARVE_MAX));

      case (state_q)
         IDLE: begin
            if (grant_cpu) begin
               state_d     = CPU_BUSY;
               mem_req_d   = 1'b1;
               mem_addr_d  = cpu_addr;
               mem_we_d    = ~cpu_rnw;
               mem_sram_d  = cpu_sram;
               mem_wdata_d = cpu_wdata;
               if (ld_req && (starve_q != STARVE_MAX)) starve_d = starve_q + 4'd1;
            end else if (ld_req) begin
               state_d     = LD_BUSY;
               mem_req_d   = 1'b1;
               mem_addr_d  = ld_addr;
               mem_we_d    = 1'b1;
               mem_sram_d  = 1'b0;
               mem_wdata_d = ld_wdata;
               starve_d    = 4'd0;
            end
         end
         CPU_BUSY: begin
            if (mem_ack) begin
               state_d   = DONE;
               mem_req_d = 1'b0;
               cpu_ack_d = 1'b1;
               // Read data is only refreshed by reads; writes leave the last value in place.
               if (!mem_we_q) cpu_rdata_d = mem_rdata;
            end
         end
         LD_BUSY: begin
            if (mem_ack) begin
               state_d   = DONE;
               mem_req_d = 1'b0;
               ld_ack_d  = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy      = (state_q != IDLE);
   assign mem_req   = mem_req_q;
   assign mem_addr  = mem_addr_q;
   assign mem_we    = mem_we_q;
   assign mem_sram  = mem_sram_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_ack   = cpu_ack_q;
   assign ld_ack    = ld_ack_q;
   assign cpu_rdata = cpu_rdata_q;

endmodule

// File: tb/tb_mapper_mem_arbiter.sv
// Directed bench for mapper_mem_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_mapper_mem_arbiter;

   localparam int ADDR_W = 27;

   logic              clk_sys = 1'b0;
   logic              reset_n;
   logic              cpu_req, cpu_rnw, cpu_sram, cpu_ack;
   logic [ADDR_W-1:0] cpu_addr;
   logic [7:0]        cpu_wdata, cpu_rdata;
   logic              ld_req, ld_ack;
   logic [ADDR_W-1:0] ld_addr;
   logic [7:0]        ld_wdata;
   logic              mem_req, mem_we, mem_sram, mem_ack;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata, mem_rdata;
   logic              busy;

   int n_checks = 0;
   int n_fail   = 0;

   mapper_mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(4'd15)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_rnw(cpu_rnw), .cpu_sram(cpu_sram),
      .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_sram(mem_sram),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for mem_req, answers it with a one-cycle mem_ack, reports which ack followed.
   task automatic serve(input logic [7:0] rd, output logic gc, output logic gl);
      int n = 0;
      while (mem_req !== 1'b1 && n < 20) begin
         @(negedge clk_sys);
         n++;
      end
      chk("mem_req_wait", {63'd0, mem_req}, 64'd1);
      mem_ack   = 1'b1;
      mem_rdata = rd;
      @(negedge clk_sys);
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
      gc = cpu_ack;
      gl = ld_ack;
      chk("ack_exclusive", {63'd0, cpu_ack & ld_ack}, 64'd0);
   endtask

   initial begin
      logic gc, gl, got_ld;
      int   ncpu;

      reset_n = 1'b0;
      cpu_req = 0; cpu_addr = '0; cpu_rnw = 1; cpu_sram = 0; cpu_wdata = 0;
      ld_req = 0; ld_addr = '0; ld_wdata = 0; mem_ack = 0; mem_rdata = 0;
      repeat (2) @(negedge clk_sys);
      chk("rst_mem_req", {63'd0, mem_req}, 0);
      chk("rst_busy", {63'd0, busy}, 0);
      chk("rst_mem_addr", {37'd0, mem_addr}, 0);
      chk("rst_cpu_rdata", {56'd0, cpu_rdata}, 0);
      chk("rst_starve", {60'd0, dut.starve_q}, 0);
      reset_n = 1'b1;

      // CPU read, mem_ack in the second mem_req cycle
      @(negedge clk_sys);
      cpu_req = 1; cpu_addr = 27'h0004000; cpu_rnw = 1; cpu_sram = 0;
      @(negedge clk_sys);
      chk("rd_mem_req1", {63'd0, mem_req}, 1);
      chk("rd_mem_we", {63'd0, mem_we}, 0);
      chk("rd_mem_addr", {37'd0, mem_addr}, 64'h4000);
      chk("rd_busy", {63'd0, busy}, 1);
      @(negedge clk_sys);
      chk("rd_mem_req2", {63'd0, mem_req}, 1);
      mem_ack = 1; mem_rdata = 8'hA5;
      @(negedge clk_sys);
      mem_ack = 0; mem_rdata = 8'h00;
      chk("rd_mem_req_drop", {63'd0, mem_req}, 0);
      chk("rd_cpu_ack", {63'd0, cpu_ack}, 1);
      chk("rd_cpu_rdata", {56'd0, cpu_rdata}, 64'hA5);
      chk("rd_ld_ack", {63'd0, ld_ack}, 0);
      chk("rd_done_busy", {63'd0, busy}, 1);
      cpu_req = 0;
      @(negedge clk_sys);
      chk("rd_ack_pulse", {63'd0, cpu_ack}, 0);
      chk("rd_idle_busy", {63'd0, busy}, 0);
      chk("rd_rdata_hold", {56'd0, cpu_rdata}, 64'hA5);

      // CPU write to SRAM
      cpu_req = 1; cpu_addr = 27'h0001234; cpu_rnw = 0; cpu_sram = 1; cpu_wdata = 8'h3C;
      @(negedge clk_sys);
      chk("wr_mem_we", {63'd0, mem_we}, 1);
      chk("wr_mem_sram", {63'd0, mem_sram}, 1);
      chk("wr_mem_wdata", {56'd0, mem_wdata}, 64'h3C);
      serve(8'h77, gc, gl);
      chk("wr_cpu_ack", {63'd0, gc}, 1);
      chk("wr_rdata_keep", {56'd0, cpu_rdata}, 64'hA5);
      cpu_req = 0; cpu_sram = 0; cpu_rnw = 1;
      @(negedge clk_sys);

      // Simultaneous requests: CPU first, then loader
      cpu_req = 1; cpu_addr = 27'h10;
      ld_req = 1; ld_addr = 27'h5555; ld_wdata = 8'hC3;
      @(negedge clk_sys);
      chk("sim_cpu_first", {37'd0, mem_addr}, 64'h10);
      chk("sim_starve1", {60'd0, dut.starve_q}, 1);
      serve(8'h11, gc, gl);
      chk("sim_cpu_ack", {62'd0, gc, gl}, 64'b10);
      chk("sim_cpu_rdata", {56'd0, cpu_rdata}, 64'h11);
      cpu_req = 0;
      repeat (2) @(negedge clk_sys);
      chk("sim_ld_req", {63'd0, mem_req}, 1);
      chk("sim_ld_we", {63'd0, mem_we}, 1);
      chk("sim_ld_sram", {63'd0, mem_sram}, 0);
      chk("sim_ld_addr", {37'd0, mem_addr}, 64'h5555);
      chk("sim_ld_wdata", {56'd0, mem_wdata}, 64'hC3);
      serve(8'h00, gc, gl);
      chk("sim_ld_ack", {62'd0, gc, gl}, 64'b01);
      chk("sim_starve0", {60'd0, dut.starve_q}, 0);
      ld_req = 0;
      @(negedge clk_sys);

      // Starvation: CPU held high with loader pending
      cpu_req = 1; cpu_addr = 27'h20; ld_req = 1; ld_addr = 27'h6666;
      ncpu = 0; got_ld = 0;
      for (int i = 0; i < 20 && !got_ld; i++) begin
         serve(i[7:0], gc, gl);
         if (gc) ncpu++;
         if (gl) got_ld = 1;
         if (gc && ncpu == 15) chk("stv_saturated", {60'd0, dut.starve_q}, 15);
      end
      chk("stv_cpu_grants", ncpu, 15);
      chk("stv_ld_grant", {63'd0, got_ld}, 1);
      chk("stv_cleared", {60'd0, dut.starve_q}, 0);
      cpu_req = 0; ld_req = 0;
      @(negedge clk_sys);
      @(negedge clk_sys);

      // Request fields change while mem_req is high
      cpu_req = 1; cpu_addr = 27'h100; cpu_rnw = 1;
      @(negedge clk_sys);
      chk("stb_addr0", {37'd0, mem_addr}, 64'h100);
      cpu_addr = 27'h200; cpu_rnw = 0; cpu_sram = 1;
      @(negedge clk_sys);
      chk("stb_addr1", {37'd0, mem_addr}, 64'h100);
      chk("stb_we", {63'd0, mem_we}, 0);
      mem_ack = 1; mem_rdata = 8'h5A;
      @(negedge clk_sys);
      mem_ack = 0; mem_rdata = 0;
      chk("stb_ack", {63'd0, cpu_ack}, 1);
      chk("stb_addr2", {37'd0, mem_addr}, 64'h100);
      cpu_req = 0; cpu_rnw = 1; cpu_sram = 0;
      @(negedge clk_sys);

      // Reset mid-transaction, then a late mem_ack
      cpu_req = 1; cpu_addr = 27'h300;
      @(negedge clk_sys);
      chk("rmo_busy_pre", {63'd0, busy}, 1);
      reset_n = 0;
      #1;
      chk("rmo_mem_req", {63'd0, mem_req}, 0);
      chk("rmo_busy", {63'd0, busy}, 0);
      chk("rmo_mem_addr", {37'd0, mem_addr}, 0);
      chk("rmo_cpu_rdata", {56'd0, cpu_rdata}, 0);
      cpu_req = 0;
      @(negedge clk_sys);
      reset_n = 1;
      @(negedge clk_sys);
      mem_ack = 1; mem_rdata = 8'hEE;
      @(negedge clk_sys);
      mem_ack = 0; mem_rdata = 0;
      chk("rmo_no_ack", {62'd0, cpu_ack, ld_ack}, 0);
      chk("rmo_idle", {63'd0, busy}, 0);
      chk("rmo_mem_req2", {63'd0, mem_req}, 0);

      // Spurious ack in IDLE
      mem_ack = 1; mem_rdata = 8'hFF;
      @(negedge clk_sys);
      mem_ack = 0; mem_rdata = 0;
      chk("spu_no_ack", {62'd0, cpu_ack, ld_ack}, 0);
      chk("spu_busy", {63'd0, busy}, 0);
      chk("spu_rdata", {56'd0, cpu_rdata}, 0);
      chk("spu_mem_addr", {37'd0, mem_addr}, 0);
      @(negedge clk_sys);
      chk("spu_still_idle", {63'd0, busy | mem_req}, 0);

      // Grant on the first edge after reset release
      reset_n = 0; cpu_req = 1; cpu_addr = 27'h40;
      @(negedge clk_sys);
      reset_n = 1;
      @(negedge clk_sys);
      chk("rel_mem_req", {63'd0, mem_req}, 1);
      chk("rel_mem_addr", {37'd0, mem_addr}, 64'h40);
      serve(8'h42, gc, gl);
      chk("rel_cpu_ack", {62'd0, gc, gl}, 64'b10);
      cpu_req = 0;
      repeat (2) @(negedge clk_sys);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
